// File: rtl/bcd_wrap_counter_pkg.sv
// rtl/bcd_wrap_counter_pkg.sv - shared BCD constants and helper functions
package bcd_wrap_counter_pkg;

    localparam int          BCD_W      = 4;
    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int          MAX_DIGITS = 4;

    // Decimal integer to packed BCD, digit 0 in bits [3:0]; digits above
    // 'digits' are left at zero.
    function automatic logic [15:0] to_bcd(input int value, input int digits);
        logic [15:0] r;
        int          t;
        r = '0;
        t = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[i*BCD_W +: BCD_W] = 4'(t % 10);
            end
            t = t / 10;
        end
        return r;
    endfunction

    // True when every nibble of the vector is a legal BCD digit.
    function automatic logic bcd_valid(input logic [15:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (vec[i*BCD_W +: BCD_W] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_wrap_counter_if.sv
// rtl/bcd_wrap_counter_if.sv - count/load/status bundle of one BCD counter field
//   master drives cin, up_dn, load, load_val; slave (the counter) drives
//   value, cout, at_max, at_min, load_err.
interface bcd_wrap_counter_if #(
    parameter int DIGITS = 2
);
    logic                  cin;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   value;
    logic                  cout;
    logic                  at_max;
    logic                  at_min;
    logic                  load_err;

    modport master (
        output cin, up_dn, load, load_val,
        input  value, cout, at_max, at_min, load_err
    );

    modport slave (
        input  cin, up_dn, load, load_val,
        output value, cout, at_max, at_min, load_err
    );
endinterface

// File: rtl/bcd_wrap_counter_digit.sv
// rtl/bcd_wrap_counter_digit.sv - single BCD digit increment/decrement cell
//   d_i       current digit
//   inc_i     step this digit up (carry in)
//   dec_i     step this digit down (borrow in)
//   d_nxt_o   digit after the step
//   carry_o   digit wraps 9 -> 0 while incrementing
//   borrow_o  digit wraps 0 -> 9 while decrementing
module bcd_wrap_counter_digit
    import bcd_wrap_counter_pkg::*;
(
    input  logic [3:0] d_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] d_nxt_o,
    output logic       carry_o,
    output logic       borrow_o
);

    assign carry_o  = inc_i & (d_i == BCD_MAX);
    assign borrow_o = dec_i & (d_i == 4'd0);

    always_comb begin
        d_nxt_o = d_i;
        if (inc_i) begin
            d_nxt_o = (d_i == BCD_MAX) ? 4'd0 : d_i + 4'd1;
        end else if (dec_i) begin
            d_nxt_o = (d_i == 4'd0) ? BCD_MAX : d_i - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_wrap_counter.sv
// rtl/bcd_wrap_counter.sv - N-digit BCD wrap-around counter with MIN..MAX range and load
//   clk       clock
//   rst       asynchronous active-high reset, value -> RST_VAL
//   bus       slave side of bcd_wrap_counter_if:
//               cin/up_dn  count enable and direction
//               load/load_val  synchronous BCD load, checked for digit and range
//               value  current count; cout  same-cycle carry/borrow to next field
//               at_max/at_min  range end flags; load_err  one-cycle rejected-load pulse
module bcd_wrap_counter
    import bcd_wrap_counter_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 99,
    parameter int RST_VAL = MIN_VAL
) (
    input  logic               clk,
    input  logic               rst,
    bcd_wrap_counter_if.slave  bus
);

    localparam int W = BCD_W * DIGITS;

    localparam logic [15:0]  MIN_BCD16 = to_bcd(MIN_VAL, DIGITS);
    localparam logic [15:0]  MAX_BCD16 = to_bcd(MAX_VAL, DIGITS);
    localparam logic [15:0]  RST_BCD16 = to_bcd(RST_VAL, DIGITS);
    localparam logic [W-1:0] MIN_BCD   = MIN_BCD16[W-1:0];
    localparam logic [W-1:0] MAX_BCD   = MAX_BCD16[W-1:0];
    localparam logic [W-1:0] RST_BCD   = RST_BCD16[W-1:0];

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_wrap_counter: DIGITS must be 1..4");
    end
    if (MIN_VAL < 0 || MAX_VAL >= 10**DIGITS) begin : g_bad_max
        $error("bcd_wrap_counter: MIN_VAL/MAX_VAL outside the digit range");
    end
    if (MIN_VAL > MAX_VAL) begin : g_bad_order
        $error("bcd_wrap_counter: MIN_VAL greater than MAX_VAL");
    end
    if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
        $error("bcd_wrap_counter: RST_VAL outside MIN_VAL..MAX_VAL");
    end

    logic [W-1:0]    value_q, value_d;
    logic            load_err_q, load_err_d;
    logic            at_max, at_min;
    logic            load_ok;
    logic [W-1:0]    ripple;
    logic [DIGITS:0] inc_c, dec_c;
    logic            unused_top;

    assign at_max = (value_q == MAX_BCD);
    assign at_min = (value_q == MIN_BCD);

    // With every digit legal, BCD vectors order the same way as the decimal
    // numbers they hold, so the range check is a plain unsigned compare.
    assign load_ok = bcd_valid(16'(bus.load_val))
                   && (bus.load_val >= MIN_BCD)
                   && (bus.load_val <= MAX_BCD);

    // Digit chain only produces value +/- 1; the MIN/MAX wrap overrides it below.
    assign inc_c[0] = bus.cin & bus.up_dn;
    assign dec_c[0] = bus.cin & ~bus.up_dn;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_wrap_counter_digit u_digit (
            .d_i      (value_q[i*BCD_W +: BCD_W]),
            .inc_i    (inc_c[i]),
            .dec_i    (dec_c[i]),
            .d_nxt_o  (ripple[i*BCD_W +: BCD_W]),
            .carry_o  (inc_c[i+1]),
            .borrow_o (dec_c[i+1])
        );
    end

    // Carry/borrow out of the top digit never matters: the range wrap has
    // already taken over before the top digit could overflow.
    assign unused_top = inc_c[DIGITS] ^ dec_c[DIGITS];

    always_comb begin
        value_d    = value_q;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                value_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.cin) begin
            if (bus.up_dn) begin
                value_d = at_max ? MIN_BCD : ripple;
            end else begin
                value_d = at_min ? MAX_BCD : ripple;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= RST_BCD;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.value    = value_q;
    assign bus.at_max   = at_max;
    assign bus.at_min   = at_min;
    assign bus.load_err = load_err_q;
    assign bus.cout     = bus.cin & ~bus.load & (bus.up_dn ? at_max : at_min);

endmodule

// File: tb/tb_bcd_wrap_counter.sv
// tb/tb_bcd_wrap_counter.sv - self-checking bench for bcd_wrap_counter
module tb_bcd_wrap_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_wrap_counter_if #(.DIGITS(2)) ia ();
    bcd_wrap_counter_if #(.DIGITS(2)) ib ();
    bcd_wrap_counter_if #(.DIGITS(2)) il ();
    bcd_wrap_counter_if #(.DIGITS(2)) ih ();

    bcd_wrap_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(99)) u_a  (.clk(clk), .rst(rst), .bus(ia));
    bcd_wrap_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12)) u_b  (.clk(clk), .rst(rst), .bus(ib));
    bcd_wrap_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(59)) u_lo (.clk(clk), .rst(rst), .bus(il));
    bcd_wrap_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(23)) u_hi (.clk(clk), .rst(rst), .bus(ih));

    assign ih.cin = il.cout;

    int n_checks = 0;
    int n_fail   = 0;
    int ma, mb, ml, mh;
    bit ea, eb, el, eh;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dec2bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r = r | (32'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    // Reference behaviour on decimal integers.
    function automatic int mdl_next(input int v, input int mn, input int mx,
                                    input bit c, input bit u, input bit ld,
                                    input logic [15:0] lv, input int digits,
                                    output bit err);
        int d, p, dig;
        bit ok;
        ok = 1'b1;
        d  = 0;
        p  = 1;
        for (int i = 0; i < digits; i++) begin
            dig = int'(lv[4*i +: 4]);
            if (dig > 9) ok = 1'b0;
            d = d + dig * p;
            p = p * 10;
        end
        if (d < mn || d > mx) ok = 1'b0;
        err = 1'b0;
        if (ld) begin
            err = !ok;
            return ok ? d : v;
        end
        if (c) begin
            if (u) return (v == mx) ? mn : v + 1;
            return (v == mn) ? mx : v - 1;
        end
        return v;
    endfunction

    function automatic bit mdl_cout(input int v, input int mn, input int mx,
                                    input bit c, input bit u, input bit ld);
        return c && !ld && (u ? (v == mx) : (v == mn));
    endfunction

    task automatic set_a(input bit c, input bit u, input bit ld, input logic [7:0] lv);
        ia.cin = c; ia.up_dn = u; ia.load = ld; ia.load_val = lv;
    endtask

    task automatic set_b(input bit c, input bit u, input bit ld, input logic [7:0] lv);
        ib.cin = c; ib.up_dn = u; ib.load = ld; ib.load_val = lv;
    endtask

    // Checks combinational outputs before the edge, then registered state after it.
    task automatic tick();
        bit lc;
        int na, nb, nl, nh;
        bit xa, xb, xl, xh;
        #1;
        chk("a_cout",  32'(ia.cout),   32'(mdl_cout(ma, 0, 99, ia.cin, ia.up_dn, ia.load)));
        chk("a_atmax", 32'(ia.at_max), 32'(ma == 99));
        chk("a_atmin", 32'(ia.at_min), 32'(ma == 0));
        chk("b_cout",  32'(ib.cout),   32'(mdl_cout(mb, 1, 12, ib.cin, ib.up_dn, ib.load)));
        chk("b_atmax", 32'(ib.at_max), 32'(mb == 12));
        chk("b_atmin", 32'(ib.at_min), 32'(mb == 1));
        lc = mdl_cout(ml, 0, 59, il.cin, il.up_dn, il.load);
        chk("lo_cout", 32'(il.cout),   32'(lc));
        chk("hi_cout", 32'(ih.cout),   32'(mdl_cout(mh, 0, 23, lc, ih.up_dn, ih.load)));
        na = mdl_next(ma, 0, 99, ia.cin, ia.up_dn, ia.load, 16'(ia.load_val), 2, xa);
        nb = mdl_next(mb, 1, 12, ib.cin, ib.up_dn, ib.load, 16'(ib.load_val), 2, xb);
        nl = mdl_next(ml, 0, 59, il.cin, il.up_dn, il.load, 16'(il.load_val), 2, xl);
        nh = mdl_next(mh, 0, 23, lc,     ih.up_dn, ih.load, 16'(ih.load_val), 2, xh);
        @(posedge clk);
        #1;
        ma = na; mb = nb; ml = nl; mh = nh;
        ea = xa; eb = xb; el = xl; eh = xh;
        chk("a_value",  32'(ia.value),    dec2bcd(ma));
        chk("a_err",    32'(ia.load_err), 32'(ea));
        chk("b_value",  32'(ib.value),    dec2bcd(mb));
        chk("b_err",    32'(ib.load_err), 32'(eb));
        chk("lo_value", 32'(il.value),    dec2bcd(ml));
        chk("lo_err",   32'(il.load_err), 32'(el));
        chk("hi_value", 32'(ih.value),    dec2bcd(mh));
        chk("hi_err",   32'(ih.load_err), 32'(eh));
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 1'b0, 1'b0, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 8'h00);
        il.cin = 1'b0; il.up_dn = 1'b1; il.load = 1'b0; il.load_val = 8'h00;
        ih.up_dn = 1'b1; ih.load = 1'b0; ih.load_val = 8'h00;
        ma = 0; mb = 1; ml = 0; mh = 0;
        ea = 1'b0; eb = 1'b0; el = 1'b0; eh = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_value", 32'(ia.value),    32'h00);
        chk("rst_a_atmin", 32'(ia.at_min),   32'h1);
        chk("rst_a_err",   32'(ia.load_err), 32'h0);
        chk("rst_b_value", 32'(ib.value),    32'h01);
        rst = 1'b0;

        // Up count with wrap and BCD ripple
        set_a(1'b0, 1'b1, 1'b1, 8'h98); tick();
        chk("a_load_98", 32'(ia.value), 32'h98);
        set_a(1'b1, 1'b1, 1'b0, 8'h00); tick();
        chk("a_up_99", 32'(ia.value), 32'h99);
        #1 chk("a_cout_at_99", 32'(ia.cout), 32'h1);
        tick(); chk("a_wrap_00", 32'(ia.value), 32'h00);
        tick(); chk("a_up_01",   32'(ia.value), 32'h01);
        set_a(1'b0, 1'b1, 1'b1, 8'h09); tick();
        set_a(1'b1, 1'b1, 1'b0, 8'h00); tick();
        chk("a_ripple_10", 32'(ia.value), 32'h10);

        // Down count with wrap inside 1..12
        set_b(1'b0, 1'b0, 1'b1, 8'h01); tick();
        set_b(1'b1, 1'b0, 1'b0, 8'h00);
        #1 chk("b_cout_wrap", 32'(ib.cout), 32'h1);
        tick(); chk("b_wrap_12", 32'(ib.value), 32'h12);
        set_b(1'b0, 1'b0, 1'b1, 8'h10); tick();
        set_b(1'b1, 1'b0, 1'b0, 8'h00); tick();
        chk("b_borrow_09", 32'(ib.value), 32'h09);

        // Rejected loads
        set_b(1'b1, 1'b1, 1'b1, 8'h3A); tick();
        chk("b_err_3a",     32'(ib.load_err), 32'h1);
        chk("b_hold_3a",    32'(ib.value),    32'h09);
        set_b(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("b_err_clr_3a", 32'(ib.load_err), 32'h0);
        set_b(1'b0, 1'b0, 1'b1, 8'h13); tick();
        chk("b_err_13",     32'(ib.load_err), 32'h1);
        chk("b_hold_13",    32'(ib.value),    32'h09);
        set_b(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("b_err_clr_13", 32'(ib.load_err), 32'h0);

        // Load wins over count
        set_a(1'b1, 1'b1, 1'b1, 8'h45);
        #1 chk("a_cout_load", 32'(ia.cout), 32'h0);
        tick(); chk("a_load_cin_45", 32'(ia.value), 32'h45);

        // Asynchronous reset in the middle of counting
        set_a(1'b1, 1'b1, 1'b0, 8'h00); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("a_async_rst", 32'(ia.value), 32'h00);
        chk("b_async_rst", 32'(ib.value), 32'h01);
        ma = 0; mb = 1; ml = 0; mh = 0;
        ea = 1'b0; eb = 1'b0; el = 1'b0; eh = 1'b0;
        @(posedge clk);
        #1;
        chk("a_rst_held", 32'(ia.value), 32'h00);
        rst = 1'b0;
        set_a(1'b0, 1'b0, 1'b0, 8'h00);

        // Chained 0..59 -> 0..23 fields
        il.cin = 1'b1; il.load = 1'b1; il.load_val = 8'h58;
        ih.load = 1'b1; ih.load_val = 8'h23;
        tick(); chk("chain_load", 32'({ih.value, il.value}), 32'h2358);
        il.load = 1'b0; ih.load = 1'b0;
        tick(); chk("chain_2359", 32'({ih.value, il.value}), 32'h2359);
        tick(); chk("chain_wrap", 32'({ih.value, il.value}), 32'h0000);
        repeat (60) tick();
        chk("chain_carry", 32'({ih.value, il.value}), 32'h0100);

        // Randomized traffic against the model; chain keeps free-running
        repeat (1500) begin
            set_a(1'(($urandom % 4) != 0), 1'($urandom), 1'(($urandom % 8) == 0),
                  (($urandom % 2) == 0) ? 8'(dec2bcd(int'($urandom_range(0, 99)))) : 8'($urandom));
            set_b(1'(($urandom % 4) != 0), 1'($urandom), 1'(($urandom % 6) == 0),
                  (($urandom % 2) == 0) ? 8'(dec2bcd(int'($urandom_range(0, 20)))) : 8'($urandom));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
